// File: rtl/pockstat_rom_arb_if.sv
// External ROM memory port shared by the download and core-fetch requesters.
// mem_req rises with mem_we/mem_addr/mem_din and holds them until the one-cycle mem_ack.
interface pockstat_rom_arb_if #(
    parameter int MEM_AW = 17
);
    logic              mem_req;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [15:0]       mem_din;
    logic [15:0]       mem_dout;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_din,
        input  mem_dout, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_din,
        output mem_dout, mem_ack
    );
endinterface

// File: rtl/pockstat_rom_arb.sv
// Arbitrates the PocketStation ROM memory port between HPS downloads (priority)
// and core ROM reads; tracks the loaded cartridge size.
module pockstat_rom_arb #(
    parameter int BIOS_WORDS = 8192,
    parameter int CART_WORDS = 65536,
    parameter int MEM_AW     = 17
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        dl_active,
    input  logic [7:0]  dl_index,
    input  logic        dl_wr,
    input  logic [24:0] dl_addr,
    input  logic [15:0] dl_data,
    output logic        dl_wait,
    input  logic        rom_read,
    input  logic        rom_sel,
    input  logic [16:0] rom_addr,
    output logic        rom_busy,
    output logic        rom_valid,
    output logic [15:0] bios_dout,
    output logic [15:0] cart_dout,
    output logic [17:0] rom_size,
    output logic [1:0]  dbg_state,
    pockstat_rom_arb_if.master mem
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2
    } state_t;

    localparam logic [31:0]       BIOS_LIM   = 32'(BIOS_WORDS);
    localparam logic [31:0]       CART_LIM   = 32'(CART_WORDS);
    localparam logic [25:0]       CART_BYTES = 26'(CART_WORDS * 2);
    localparam logic [MEM_AW-1:0] BIOS_BASE  = MEM_AW'(CART_WORDS);

    state_t            state_q, state_d;
    logic              wr_pend_q, wr_pend_d;
    logic              wr_ok_q, wr_ok_d;
    logic              wr_cart_q, wr_cart_d;
    logic [24:0]       wr_addr_q, wr_addr_d;
    logic [15:0]       wr_data_q, wr_data_d;
    logic [MEM_AW-1:0] wr_maddr_q, wr_maddr_d;
    logic              rd_pend_q, rd_pend_d;
    logic              rd_ok_q, rd_ok_d;
    logic              rd_sel_q, rd_sel_d;
    logic [MEM_AW-1:0] rd_maddr_q, rd_maddr_d;
    logic              rom_valid_q, rom_valid_d;
    logic [15:0]       bios_q, bios_d;
    logic [15:0]       cart_q, cart_d;
    logic [17:0]       rom_size_q, rom_size_d;
    logic              dl_active_q, dl_active_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic [15:0]       mem_din_q, mem_din_d;

    logic [31:0]       wr_word;
    logic [31:0]       rd_word;
    logic              wr_in_range;
    logic              rd_in_range;
    logic [25:0]       size_sum;
    logic [25:0]       size_sat;

    // Range checks and region mapping are resolved once, when the request is latched.
    always_comb begin
        wr_word     = {8'd0, dl_addr[24:1]};
        rd_word     = {15'd0, rom_addr};
        wr_in_range = (dl_index == 8'd1) ? (wr_word < CART_LIM) :
                      (dl_index == 8'd0) ? (wr_word < BIOS_LIM) : 1'b0;
        rd_in_range = rom_sel ? (rd_word < CART_LIM) : (rd_word < BIOS_LIM);
        size_sum    = {1'b0, wr_addr_q} + 26'd2;
        size_sat    = (size_sum > CART_BYTES) ? CART_BYTES : size_sum;
    end

    always_comb begin
        state_d     = state_q;
        wr_pend_d   = wr_pend_q;
        wr_ok_d     = wr_ok_q;
        wr_cart_d   = wr_cart_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        wr_maddr_d  = wr_maddr_q;
        rd_pend_d   = rd_pend_q;
        rd_ok_d     = rd_ok_q;
        rd_sel_d    = rd_sel_q;
        rd_maddr_d  = rd_maddr_q;
        rom_valid_d = 1'b0;
        bios_d      = bios_q;
        cart_d      = cart_q;
        rom_size_d  = rom_size_q;
        dl_active_d = dl_active;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;

        if (dl_wr && !wr_pend_q) begin
            wr_pend_d  = 1'b1;
            wr_ok_d    = wr_in_range;
            wr_cart_d  = (dl_index == 8'd1);
            wr_addr_d  = dl_addr;
            wr_data_d  = dl_data;
            wr_maddr_d = ((dl_index == 8'd1) ? '0 : BIOS_BASE) + dl_addr[MEM_AW:1];
        end else if (wr_pend_q && !wr_ok_q) begin
            wr_pend_d = 1'b0;
        end

        // Out-of-range reads complete on their own with a valid pulse and no data update.
        if (rom_read && !rd_pend_q) begin
            rd_pend_d  = 1'b1;
            rd_ok_d    = rd_in_range;
            rd_sel_d   = rom_sel;
            rd_maddr_d = (rom_sel ? '0 : BIOS_BASE) + MEM_AW'(rom_addr);
        end else if (rd_pend_q && !rd_ok_q) begin
            rd_pend_d   = 1'b0;
            rom_valid_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (wr_pend_q && wr_ok_q) begin
                    state_d    = S_WRITE;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b1;
                    mem_addr_d = wr_maddr_q;
                    mem_din_d  = wr_data_q;
                end else if (rd_pend_q && rd_ok_q && !dl_active) begin
                    state_d    = S_READ;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = rd_maddr_q;
                end
            end
            S_WRITE: begin
                if (mem.mem_ack) begin
                    state_d   = S_IDLE;
                    mem_req_d = 1'b0;
                    wr_pend_d = 1'b0;
                    if (wr_cart_q && (size_sat > {8'd0, rom_size_q})) begin
                        rom_size_d = size_sat[17:0];
                    end
                end
            end
            S_READ: begin
                if (mem.mem_ack) begin
                    state_d     = S_IDLE;
                    mem_req_d   = 1'b0;
                    rd_pend_d   = 1'b0;
                    rom_valid_d = 1'b1;
                    if (rd_sel_q) begin
                        cart_d = mem.mem_dout;
                    end else begin
                        bios_d = mem.mem_dout;
                    end
                end
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end
        endcase

        // A new cart download restarts size tracking.
        if (dl_active && !dl_active_q && (dl_index == 8'd1)) begin
            rom_size_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            wr_pend_q   <= 1'b0;
            wr_ok_q     <= 1'b0;
            wr_cart_q   <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_maddr_q  <= '0;
            rd_pend_q   <= 1'b0;
            rd_ok_q     <= 1'b0;
            rd_sel_q    <= 1'b0;
            rd_maddr_q  <= '0;
            rom_valid_q <= 1'b0;
            bios_q      <= '0;
            cart_q      <= '0;
            rom_size_q  <= '0;
            dl_active_q <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_pend_q   <= wr_pend_d;
            wr_ok_q     <= wr_ok_d;
            wr_cart_q   <= wr_cart_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wr_maddr_q  <= wr_maddr_d;
            rd_pend_q   <= rd_pend_d;
            rd_ok_q     <= rd_ok_d;
            rd_sel_q    <= rd_sel_d;
            rd_maddr_q  <= rd_maddr_d;
            rom_valid_q <= rom_valid_d;
            bios_q      <= bios_d;
            cart_q      <= cart_d;
            rom_size_q  <= rom_size_d;
            dl_active_q <= dl_active_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
        end
    end

    assign dl_wait      = wr_pend_q;
    assign rom_busy     = rd_pend_q;
    assign rom_valid    = rom_valid_q;
    assign bios_dout    = bios_q;
    assign cart_dout    = cart_q;
    assign rom_size     = rom_size_q;
    assign dbg_state    = state_q;
    assign mem.mem_req  = mem_req_q;
    assign mem.mem_we   = mem_we_q;
    assign mem.mem_addr = mem_addr_q;
    assign mem.mem_din  = mem_din_q;

endmodule

// File: tb/tb_pockstat_rom_arb.sv
// Directed bench for pockstat_rom_arb: download writes, core reads, priority,
// dropped requests and asynchronous reset with an in-flight request.
module tb_pockstat_rom_arb;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        dl_active;
    logic [7:0]  dl_index;
    logic        dl_wr;
    logic [24:0] dl_addr;
    logic [15:0] dl_data;
    logic        dl_wait;
    logic        rom_read;
    logic        rom_sel;
    logic [16:0] rom_addr;
    logic        rom_busy;
    logic        rom_valid;
    logic [15:0] bios_dout;
    logic [15:0] cart_dout;
    logic [17:0] rom_size;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int n_valid  = 0;
    int valid_mark;

    pockstat_rom_arb_if #(.MEM_AW(17)) mem_bus ();

    pockstat_rom_arb #(
        .BIOS_WORDS(8192),
        .CART_WORDS(65536),
        .MEM_AW(17)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .dl_active(dl_active),
        .dl_index(dl_index),
        .dl_wr(dl_wr),
        .dl_addr(dl_addr),
        .dl_data(dl_data),
        .dl_wait(dl_wait),
        .rom_read(rom_read),
        .rom_sel(rom_sel),
        .rom_addr(rom_addr),
        .rom_busy(rom_busy),
        .rom_valid(rom_valid),
        .bios_dout(bios_dout),
        .cart_dout(cart_dout),
        .rom_size(rom_size),
        .dbg_state(dbg_state),
        .mem(mem_bus)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    always @(negedge clk) begin
        if (rom_valid === 1'b1) n_valid++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n          = 1'b0;
        dl_active        = 1'b0;
        dl_index         = 8'd0;
        dl_wr            = 1'b0;
        dl_addr          = '0;
        dl_data          = '0;
        rom_read         = 1'b0;
        rom_sel          = 1'b0;
        rom_addr         = '0;
        mem_bus.mem_ack  = 1'b0;
        mem_bus.mem_dout = '0;

        // Reset values
        tick();
        tick();
        check("rst dl_wait", dl_wait, 0);
        check("rst rom_busy", rom_busy, 0);
        check("rst rom_valid", rom_valid, 0);
        check("rst bios_dout", bios_dout, 0);
        check("rst cart_dout", cart_dout, 0);
        check("rst rom_size", rom_size, 0);
        check("rst mem_req", mem_bus.mem_req, 0);
        check("rst mem_we", mem_bus.mem_we, 0);
        check("rst mem_addr", mem_bus.mem_addr, 0);
        check("rst mem_din", mem_bus.mem_din, 0);
        check("rst state", dbg_state, 0);
        reset_n = 1'b1;
        tick();

        // Cart write 0xA55A at byte 0x10, ack three cycles after the latch
        dl_active = 1'b1;
        dl_index  = 8'd1;
        tick();
        dl_wr   = 1'b1;
        dl_addr = 25'h10;
        dl_data = 16'hA55A;
        tick();
        dl_wr = 1'b0;
        check("wr c0 dl_wait", dl_wait, 1);
        check("wr c0 mem_req", mem_bus.mem_req, 0);
        tick();
        check("wr c1 mem_req", mem_bus.mem_req, 1);
        check("wr c1 mem_we", mem_bus.mem_we, 1);
        check("wr c1 mem_addr", mem_bus.mem_addr, 32'h00008);
        check("wr c1 mem_din", mem_bus.mem_din, 32'hA55A);
        check("wr c1 state", dbg_state, 1);
        check("wr c1 dl_wait", dl_wait, 1);
        tick();
        check("wr c2 dl_wait", dl_wait, 1);
        check("wr c2 mem_addr", mem_bus.mem_addr, 32'h00008);
        tick();
        check("wr c3 dl_wait", dl_wait, 1);
        mem_bus.mem_ack = 1'b1;
        tick();
        mem_bus.mem_ack = 1'b0;
        check("wr c4 dl_wait", dl_wait, 0);
        check("wr c4 mem_req", mem_bus.mem_req, 0);
        check("wr c4 rom_size", rom_size, 32'h12);
        check("wr c4 state", dbg_state, 0);
        dl_active = 1'b0;
        tick();

        // BIOS read word 5, zero-wait memory
        rom_read = 1'b1;
        rom_sel  = 1'b0;
        rom_addr = 17'h5;
        tick();
        rom_read = 1'b0;
        check("rd c0 rom_busy", rom_busy, 1);
        check("rd c0 mem_req", mem_bus.mem_req, 0);
        tick();
        check("rd c1 mem_req", mem_bus.mem_req, 1);
        check("rd c1 mem_we", mem_bus.mem_we, 0);
        check("rd c1 mem_addr", mem_bus.mem_addr, 32'h10005);
        check("rd c1 state", dbg_state, 2);
        tick();
        check("rd c2 rom_valid", rom_valid, 0);
        mem_bus.mem_ack  = 1'b1;
        mem_bus.mem_dout = 16'h1234;
        tick();
        mem_bus.mem_ack = 1'b0;
        check("rd c3 rom_valid", rom_valid, 1);
        check("rd c3 bios_dout", bios_dout, 32'h1234);
        check("rd c3 cart_dout", cart_dout, 0);
        check("rd c3 rom_busy", rom_busy, 0);
        tick();
        check("rd c4 rom_valid", rom_valid, 0);

        // Simultaneous cart write and cart read: write served first
        valid_mark = n_valid;
        dl_index = 8'd1;
        dl_wr    = 1'b1;
        dl_addr  = 25'h20;
        dl_data  = 16'hBEEF;
        rom_read = 1'b1;
        rom_sel  = 1'b1;
        rom_addr = 17'h3;
        tick();
        dl_wr    = 1'b0;
        rom_read = 1'b0;
        check("sim c0 dl_wait", dl_wait, 1);
        check("sim c0 rom_busy", rom_busy, 1);
        tick();
        check("sim c1 mem_we", mem_bus.mem_we, 1);
        check("sim c1 mem_addr", mem_bus.mem_addr, 32'h10);
        tick();
        mem_bus.mem_ack = 1'b1;
        tick();
        mem_bus.mem_ack = 1'b0;
        check("sim c3 mem_req", mem_bus.mem_req, 0);
        check("sim c3 dl_wait", dl_wait, 0);
        check("sim c3 rom_busy", rom_busy, 1);
        check("sim c3 rom_size", rom_size, 32'h22);
        tick();
        check("sim c4 mem_req", mem_bus.mem_req, 1);
        check("sim c4 mem_we", mem_bus.mem_we, 0);
        check("sim c4 mem_addr", mem_bus.mem_addr, 32'h3);
        mem_bus.mem_dout = 16'h5678;
        tick();
        mem_bus.mem_ack = 1'b1;
        tick();
        mem_bus.mem_ack = 1'b0;
        check("sim c6 rom_valid", rom_valid, 1);
        check("sim c6 cart_dout", cart_dout, 32'h5678);
        check("sim c6 bios_dout", bios_dout, 32'h1234);
        tick();
        tick();
        check("sim valid count", n_valid - valid_mark, 1);

        // Read held off while a download is active (index 0 rise keeps rom_size)
        dl_index  = 8'd0;
        dl_active = 1'b1;
        rom_read  = 1'b1;
        rom_sel   = 1'b0;
        rom_addr  = 17'h7;
        tick();
        rom_read = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("hold mem_req", mem_bus.mem_req, 0);
            check("hold rom_busy", rom_busy, 1);
        end
        check("hold rom_size", rom_size, 32'h22);
        dl_active = 1'b0;
        tick();
        check("hold issue mem_req", mem_bus.mem_req, 1);
        check("hold issue mem_addr", mem_bus.mem_addr, 32'h10007);
        mem_bus.mem_dout = 16'h9ABC;
        mem_bus.mem_ack  = 1'b1;
        tick();
        mem_bus.mem_ack = 1'b0;
        check("hold rom_valid", rom_valid, 1);
        check("hold bios_dout", bios_dout, 32'h9ABC);
        tick();

        // Dropped requests: bad index, out-of-range BIOS write, out-of-range read
        dl_index  = 8'd2;
        dl_active = 1'b1;
        tick();
        dl_wr   = 1'b1;
        dl_addr = 25'h0;
        dl_data = 16'h1111;
        tick();
        dl_wr = 1'b0;
        check("drop idx c0 dl_wait", dl_wait, 1);
        tick();
        check("drop idx c1 dl_wait", dl_wait, 0);
        check("drop idx c1 mem_req", mem_bus.mem_req, 0);
        dl_index = 8'd0;
        dl_wr    = 1'b1;
        dl_addr  = 25'h4000;
        tick();
        dl_wr = 1'b0;
        check("drop bios c0 dl_wait", dl_wait, 1);
        tick();
        check("drop bios c1 dl_wait", dl_wait, 0);
        check("drop bios c1 mem_req", mem_bus.mem_req, 0);
        check("drop rom_size", rom_size, 32'h22);
        dl_active = 1'b0;
        rom_read  = 1'b1;
        rom_sel   = 1'b0;
        rom_addr  = 17'h2000;
        tick();
        rom_read = 1'b0;
        check("drop rd c0 rom_busy", rom_busy, 1);
        check("drop rd c0 rom_valid", rom_valid, 0);
        tick();
        check("drop rd c1 rom_busy", rom_busy, 0);
        check("drop rd c1 rom_valid", rom_valid, 1);
        check("drop rd c1 mem_req", mem_bus.mem_req, 0);
        check("drop rd c1 bios_dout", bios_dout, 32'h9ABC);

        // New cart download clears rom_size
        dl_index  = 8'd1;
        dl_active = 1'b1;
        tick();
        check("cart restart rom_size", rom_size, 0);
        dl_active = 1'b0;
        tick();

        // Asynchronous reset with a read in flight; late ack is ignored
        rom_read = 1'b1;
        rom_sel  = 1'b1;
        rom_addr = 17'h1;
        tick();
        rom_read = 1'b0;
        tick();
        check("arst pre mem_req", mem_bus.mem_req, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst mem_req", mem_bus.mem_req, 0);
        check("arst rom_busy", rom_busy, 0);
        check("arst mem_addr", mem_bus.mem_addr, 0);
        check("arst bios_dout", bios_dout, 0);
        check("arst state", dbg_state, 0);
        valid_mark = n_valid;
        tick();
        reset_n = 1'b1;
        tick();
        mem_bus.mem_dout = 16'hDEAD;
        mem_bus.mem_ack  = 1'b1;
        tick();
        mem_bus.mem_ack = 1'b0;
        check("arst late rom_valid", rom_valid, 0);
        tick();
        check("arst late cart_dout", cart_dout, 0);
        check("arst late mem_req", mem_bus.mem_req, 0);
        check("arst late valid count", n_valid - valid_mark, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
